// File: rtl/register_file_if.sv
// Decode/write-back side of the register file: two operand read ports,
// one write port and a debug read port that bypasses nothing.
interface register_file_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic [ADDR_W-1:0] src1;
  logic [ADDR_W-1:0] src2;
  logic [DATA_W-1:0] reg1val;
  logic [DATA_W-1:0] reg2val;
  logic              wb_en;
  logic [ADDR_W-1:0] wb_dest;
  logic [DATA_W-1:0] wb_value;
  logic [ADDR_W-1:0] dbg_addr;
  logic [DATA_W-1:0] dbg_data;

  modport master (
    output src1, src2, wb_en, wb_dest, wb_value, dbg_addr,
    input  reg1val, reg2val, dbg_data
  );

  modport slave (
    input  src1, src2, wb_en, wb_dest, wb_value, dbg_addr,
    output reg1val, reg2val, dbg_data
  );
endinterface

// File: rtl/register_file.sv
// 32x32 MIPS register file: flop storage with async reset, hard-wired r0,
// and same-cycle write-to-read bypass on both operand ports.
module register_file #(
  parameter int DATA_W           = 32,
  parameter int ADDR_W           = 5,
  parameter int RESET_INDEX_INIT = 1
) (
  input logic           clk,
  input logic           rst,
  register_file_if.slave rf
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic              writeAccept;

  // An X on wb_en makes this condition non-true, so storage is left untouched.
  assign writeAccept = (rf.wb_en == 1'b1) && !rst && (rf.wb_dest != '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= (RESET_INDEX_INIT != 0) ? DATA_W'(i) : '0;
      end
    end else if (writeAccept) begin
      mem_q[rf.wb_dest] <= rf.wb_value;
    end
  end

  always_comb begin
    rf.reg1val = mem_q[rf.src1];
    if (rf.src1 == '0) begin
      rf.reg1val = '0;
    end else if (writeAccept && (rf.wb_dest == rf.src1)) begin
      rf.reg1val = rf.wb_value;
    end
  end

  always_comb begin
    rf.reg2val = mem_q[rf.src2];
    if (rf.src2 == '0) begin
      rf.reg2val = '0;
    end else if (writeAccept && (rf.wb_dest == rf.src2)) begin
      rf.reg2val = rf.wb_value;
    end
  end

  always_comb begin
    rf.dbg_data = mem_q[rf.dbg_addr];
    if (rf.dbg_addr == '0) begin
      rf.dbg_data = '0;
    end
  end

endmodule

// File: tb/tb_register_file.sv
// Directed bench for register_file: one instance with index reset values,
// one with zero reset values, both fed the same stimulus.
module tb_register_file;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  register_file_if #(.DATA_W(32), .ADDR_W(5)) ifIdx ();
  register_file_if #(.DATA_W(32), .ADDR_W(5)) ifZero ();

  register_file #(.DATA_W(32), .ADDR_W(5), .RESET_INDEX_INIT(1)) dutIdx (
    .clk (clk),
    .rst (rst),
    .rf  (ifIdx.slave)
  );

  register_file #(.DATA_W(32), .ADDR_W(5), .RESET_INDEX_INIT(0)) dutZero (
    .clk (clk),
    .rst (rst),
    .rf  (ifZero.slave)
  );

  assign ifZero.src1     = ifIdx.src1;
  assign ifZero.src2     = ifIdx.src2;
  assign ifZero.wb_en    = ifIdx.wb_en;
  assign ifZero.wb_dest  = ifIdx.wb_dest;
  assign ifZero.wb_value = ifIdx.wb_value;
  assign ifZero.dbg_addr = ifIdx.dbg_addr;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic applyStimulus(input logic [4:0] s1, input logic [4:0] s2,
                               input logic en, input logic [4:0] dest,
                               input logic [31:0] val, input logic [4:0] dbg);
    ifIdx.src1     = s1;
    ifIdx.src2     = s2;
    ifIdx.wb_en    = en;
    ifIdx.wb_dest  = dest;
    ifIdx.wb_value = val;
    ifIdx.dbg_addr = dbg;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Inputs change on the falling edge; outputs are sampled 1ns later.
  task automatic toNegedge();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst    = 1'b1;
    applyStimulus(5'd0, 5'd0, 1'b0, 5'd0, 32'h0, 5'd0);
    @(negedge clk);

    for (int i = 0; i < 32; i++) begin
      applyStimulus(5'(i), 5'(31 - i), 1'b0, 5'd0, 32'h0, 5'(i));
      #1;
      checkOutput("rstIdx_reg1", ifIdx.reg1val, 32'(i));
      checkOutput("rstIdx_reg2", ifIdx.reg2val, 32'(31 - i));
      checkOutput("rstIdx_dbg", ifIdx.dbg_data, 32'(i));
      checkOutput("rstZero_reg1", ifZero.reg1val, 32'h0);
      checkOutput("rstZero_reg2", ifZero.reg2val, 32'h0);
      checkOutput("rstZero_dbg", ifZero.dbg_data, 32'h0);
    end

    // A write presented while reset is high must be ignored and not bypassed.
    applyStimulus(5'd5, 5'd0, 1'b1, 5'd5, 32'hFFFF_0000, 5'd5);
    #1;
    checkOutput("rstNoBypass", ifIdx.reg1val, 32'd5);
    toNegedge();
    checkOutput("rstNoWrite", ifIdx.dbg_data, 32'd5);

    rst = 1'b0;
    applyStimulus(5'd0, 5'd0, 1'b1, 5'd5, 32'hDEAD_BEEF, 5'd5);
    toNegedge();
    applyStimulus(5'd5, 5'd0, 1'b0, 5'd0, 32'h0, 5'd5);
    #1;
    checkOutput("wr5_reg1", ifIdx.reg1val, 32'hDEAD_BEEF);
    checkOutput("wr5_dbg", ifIdx.dbg_data, 32'hDEAD_BEEF);
    checkOutput("wr5_dbgZero", ifZero.dbg_data, 32'hDEAD_BEEF);

    @(negedge clk);
    applyStimulus(5'd9, 5'd9, 1'b1, 5'd9, 32'h0000_1234, 5'd9);
    #1;
    checkOutput("byp_reg1", ifIdx.reg1val, 32'h0000_1234);
    checkOutput("byp_reg2", ifIdx.reg2val, 32'h0000_1234);
    checkOutput("byp_dbgRaw", ifIdx.dbg_data, 32'd9);
    checkOutput("byp_zeroRaw", ifZero.dbg_data, 32'd0);
    @(posedge clk);
    #1;
    checkOutput("byp_dbgAfter", ifIdx.dbg_data, 32'h0000_1234);

    @(negedge clk);
    applyStimulus(5'd0, 5'd0, 1'b1, 5'd0, 32'hFFFF_FFFF, 5'd0);
    #1;
    checkOutput("r0_sameCycle", ifIdx.reg1val, 32'h0);
    checkOutput("r0_sameCycle2", ifIdx.reg2val, 32'h0);
    toNegedge();
    applyStimulus(5'd0, 5'd0, 1'b0, 5'd0, 32'h0, 5'd0);
    #1;
    checkOutput("r0_after", ifIdx.reg1val, 32'h0);
    checkOutput("r0_dbg", ifIdx.dbg_data, 32'h0);

    @(negedge clk);
    applyStimulus(5'd3, 5'd4, 1'b1, 5'd3, 32'hA, 5'd3);
    #1;
    checkOutput("b2b_c1_reg1", ifIdx.reg1val, 32'hA);
    checkOutput("b2b_c1_reg2", ifIdx.reg2val, 32'd4);
    toNegedge();
    applyStimulus(5'd3, 5'd4, 1'b1, 5'd3, 32'hB, 5'd3);
    #1;
    checkOutput("b2b_c2_reg1", ifIdx.reg1val, 32'hB);
    checkOutput("b2b_c2_dbg", ifIdx.dbg_data, 32'hA);
    toNegedge();
    applyStimulus(5'd3, 5'd4, 1'b1, 5'd4, 32'hC, 5'd4);
    #1;
    checkOutput("b2b_c3_reg1", ifIdx.reg1val, 32'hB);
    checkOutput("b2b_c3_reg2", ifIdx.reg2val, 32'hC);
    toNegedge();
    applyStimulus(5'd3, 5'd4, 1'b0, 5'd0, 32'h0, 5'd4);
    #1;
    checkOutput("b2b_r3", ifIdx.reg1val, 32'hB);
    checkOutput("b2b_r4", ifIdx.reg2val, 32'hC);
    checkOutput("b2b_dbg4", ifIdx.dbg_data, 32'hC);

    @(negedge clk);
    applyStimulus(5'd7, 5'd5, 1'b1, 5'd7, 32'h55, 5'd7);
    @(posedge clk);
    #1;
    applyStimulus(5'd7, 5'd5, 1'b0, 5'd0, 32'h0, 5'd7);
    #1;
    checkOutput("async_pre", ifIdx.reg1val, 32'h55);
    rst = 1'b1;
    #1;
    checkOutput("async_reg1", ifIdx.reg1val, 32'd7);
    checkOutput("async_reg2", ifIdx.reg2val, 32'd5);
    checkOutput("async_zero", ifZero.reg1val, 32'h0);
    @(negedge clk);
    applyStimulus(5'd7, 5'd5, 1'b1, 5'd7, 32'h99, 5'd7);
    #1;
    checkOutput("async_noBypass", ifIdx.reg1val, 32'd7);
    toNegedge();
    rst = 1'b0;
    applyStimulus(5'd7, 5'd5, 1'b0, 5'd0, 32'h0, 5'd7);
    #1;
    checkOutput("async_release", ifIdx.reg1val, 32'd7);
    checkOutput("async_dbg", ifIdx.dbg_data, 32'd7);

    // First rising edge after release must accept a write.
    applyStimulus(5'd7, 5'd5, 1'b1, 5'd7, 32'h77, 5'd7);
    toNegedge();
    applyStimulus(5'd7, 5'd5, 1'b0, 5'd0, 32'h0, 5'd7);
    #1;
    checkOutput("firstWrite", ifIdx.dbg_data, 32'h77);

    applyStimulus(5'd6, 5'd0, 1'bx, 5'd6, 32'h0, 5'd6);
    toNegedge();
    applyStimulus(5'd6, 5'd0, 1'b0, 5'd0, 32'h0, 5'd6);
    #1;
    checkOutput("xEnable_dbg", ifIdx.dbg_data, 32'd6);
    checkOutput("xEnable_reg1", ifIdx.reg1val, 32'd6);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
